// File: rtl/pe_stream_bridge.sv
// rtl/pe_stream_bridge.sv - stream-to-BRAM front end and result drain for the 8x8 PE-array controller
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready
//                       operand stream: A (L*L words, row-major) then B (L*L words)
//   m_data/m_valid/m_last/m_ready
//                       result stream: L*L words read back from BRAM
//   bram_addr/bram_wrdata/bram_we/bram_rddata
//                       BRAM port A, byte addressed, read data one cycle after address
//   pe_start, pe_done   controller handshake (one-cycle start, done held several cycles)
//   busy, err           state != IDLE; sticky framing error
//   cycle_cnt           only with PE_STREAM_BRIDGE_CYCLE_CNT_EN: controller compute cycles
//
// Optional feature macro: PE_STREAM_BRIDGE_CYCLE_CNT_EN

module pe_stream_bridge #(
  parameter int DATA_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LINE_SIZE       = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_valid,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_wrdata,
  output logic [DATA_WIDTH/8-1:0]    bram_we,
  input  logic [DATA_WIDTH-1:0]      bram_rddata,
  output logic                       pe_start,
  input  logic                       pe_done,
  output logic                       busy,
`ifdef PE_STREAM_BRIDGE_CYCLE_CNT_EN
  output logic [31:0]                cycle_cnt,
`endif
  output logic                       err
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int RES_WORDS = LINE_SIZE * LINE_SIZE;
  localparam int JOB_WORDS = 2 * RES_WORDS;
  localparam logic [CNT_WIDTH-1:0]  JOB_LAST = CNT_WIDTH'(JOB_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0]  RES_LAST = CNT_WIDTH'(RES_WORDS - 1);
  localparam logic [BYTES-1:0]      WE_ALL   = '1;

  // DRAIN_ADDR: read address is on the bus; DRAIN_WAIT: RAM output valid, captured
  // into m_data; DRAIN_OUT: result held until downstream takes it.
  typedef enum logic [2:0] {
    IDLE,
    FILL,
    KICK,
    BUSY,
    DRAIN_ADDR,
    DRAIN_WAIT,
    DRAIN_OUT
  } state_t;

  state_t                     state, state_d;
  logic [CNT_WIDTH-1:0]       wr_cnt, wr_cnt_d;
  logic [CNT_WIDTH-1:0]       rd_cnt, rd_cnt_d;
  logic                       done_q;
  logic                       s_ready_d;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_d;
  logic [DATA_WIDTH-1:0]      bram_wrdata_d;
  logic [BYTES-1:0]           bram_we_d;
  logic [DATA_WIDTH-1:0]      m_data_d;
  logic                       m_valid_d;
  logic                       m_last_d;
  logic                       pe_start_d;
  logic                       err_d;
  logic                       accept;

  function automatic logic [BRAM_ADDR_WIDTH-1:0] word_addr(input logic [CNT_WIDTH-1:0] k);
    return BRAM_ADDR_WIDTH'(32'(k) * BYTES);
  endfunction

  assign accept = s_valid & s_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    state_d       = state;
    wr_cnt_d      = wr_cnt;
    rd_cnt_d      = rd_cnt;
    s_ready_d     = 1'b0;
    bram_addr_d   = bram_addr;
    bram_wrdata_d = bram_wrdata;
    bram_we_d     = '0;
    m_data_d      = m_data;
    m_valid_d     = m_valid;
    m_last_d      = m_last;
    pe_start_d    = 1'b0;
    err_d         = err;

    case (state)
      IDLE: begin
        // A done still high from the previous job blocks new input until it falls.
        s_ready_d = ~pe_done;
        if (accept) begin
          bram_addr_d   = word_addr('0);
          bram_wrdata_d = s_data;
          bram_we_d     = WE_ALL;
          if (s_last) begin
            err_d    = 1'b1;
            wr_cnt_d = '0;
          end else begin
            state_d   = FILL;
            wr_cnt_d  = CNT_WIDTH'(1);
            s_ready_d = 1'b1;
          end
        end
      end

      FILL: begin
        s_ready_d = 1'b1;
        if (accept) begin
          bram_addr_d   = word_addr(wr_cnt);
          bram_wrdata_d = s_data;
          bram_we_d     = WE_ALL;
          wr_cnt_d      = wr_cnt + 1'b1;
          if (wr_cnt == JOB_LAST) begin
            // A missing s_last is flagged but the full job is still computed.
            if (!s_last) begin
              err_d = 1'b1;
            end
            state_d   = KICK;
            s_ready_d = 1'b0;
            wr_cnt_d  = '0;
          end else if (s_last) begin
            err_d     = 1'b1;
            state_d   = IDLE;
            s_ready_d = ~pe_done;
            wr_cnt_d  = '0;
          end
        end
      end

      // The final write is on the bus this cycle; start goes out on the next one.
      KICK: begin
        pe_start_d = 1'b1;
        state_d    = BUSY;
      end

      BUSY: begin
        if (pe_done && !done_q) begin
          state_d     = DRAIN_ADDR;
          rd_cnt_d    = '0;
          bram_addr_d = word_addr('0);
        end
      end

      DRAIN_ADDR: begin
        state_d = DRAIN_WAIT;
      end

      DRAIN_WAIT: begin
        m_data_d  = bram_rddata;
        m_valid_d = 1'b1;
        m_last_d  = (rd_cnt == RES_LAST);
        state_d   = DRAIN_OUT;
      end

      DRAIN_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (rd_cnt == RES_LAST) begin
            state_d   = IDLE;
            rd_cnt_d  = '0;
            s_ready_d = ~pe_done;
          end else begin
            rd_cnt_d    = rd_cnt + 1'b1;
            bram_addr_d = word_addr(rd_cnt + 1'b1);
            state_d     = DRAIN_ADDR;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      done_q      <= 1'b0;
      s_ready     <= 1'b0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
      bram_we     <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      pe_start    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      wr_cnt      <= wr_cnt_d;
      rd_cnt      <= rd_cnt_d;
      done_q      <= pe_done;
      s_ready     <= s_ready_d;
      bram_addr   <= bram_addr_d;
      bram_wrdata <= bram_wrdata_d;
      bram_we     <= bram_we_d;
      m_data      <= m_data_d;
      m_valid     <= m_valid_d;
      m_last      <= m_last_d;
      pe_start    <= pe_start_d;
      err         <= err_d;
    end
  end

`ifdef PE_STREAM_BRIDGE_CYCLE_CNT_EN
  // pe_start is high in the first BUSY cycle, so counting restarts from there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (pe_start) begin
      cycle_cnt <= '0;
    end else if (state == BUSY) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`else
  // No compute-latency counter in this build.
`endif

endmodule

// File: tb/tb_pe_stream_bridge.sv
// tb/tb_pe_stream_bridge.sv - self-checking bench for pe_stream_bridge

module tb_pe_stream_bridge;

  localparam int JOB = 128;
  localparam int RES = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [14:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;
  logic [31:0] bram_rddata;
  logic        pe_start;
  logic        pe_done;
  logic        busy;
  logic        err;

  logic        ctl_we;
  logic [7:0]  ctl_addr;
  logic [31:0] ctl_data;

  logic [31:0] mem [0:255];
  logic [31:0] job [0:JOB-1];
  logic [31:0] res [0:RES-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, n_writes = 0, n_starts = 0, last_we_cyc = 0, start_cyc = 0;
  int bad_we = 0, bad_addr = 0;
  int w0, s0;

  pe_stream_bridge dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .bram_we(bram_we),
    .bram_rddata(bram_rddata), .pe_start(pe_start), .pe_done(pe_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Shared BRAM: port A from the bridge, a second write port for the controller model.
  always @(posedge clk) begin
    if (ctl_we) mem[ctl_addr] <= ctl_data;
    else if (bram_we == 4'hF) mem[bram_addr[9:2]] <= bram_wrdata;
    bram_rddata <= mem[bram_addr[9:2]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_we != 4'h0) begin
      n_writes++;
      last_we_cyc = cyc;
      if (bram_we != 4'hF) bad_we++;
    end
    if (bram_addr[1:0] != 2'b00 || bram_addr[14:10] != 5'd0) bad_addr++;
    if (pe_start) begin
      n_starts++;
      start_cyc = cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string p);
    check({p, "_s_ready"}, s_ready, 0);
    check({p, "_bram_we"}, bram_we, 0);
    check({p, "_bram_addr"}, bram_addr, 0);
    check({p, "_bram_wrdata"}, bram_wrdata, 0);
    check({p, "_m_data"}, m_data, 0);
    check({p, "_m_valid"}, m_valid, 0);
    check({p, "_m_last"}, m_last, 0);
    check({p, "_pe_start"}, pe_start, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_err"}, err, 0);
  endtask

  task automatic fill_job(input bit directed);
    for (int k = 0; k < JOB; k++)
      job[k] = directed ? ((k < RES) ? 32'(k + 1) : 32'd2) : $urandom;
  endtask

  task automatic stream(input int n, input int last_at, input bit gaps);
    int  k = 0;
    int  guard = 0;
    bit  hs;
    while (k < n && guard < 4000) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = job[k];
      s_last  = (k == last_at);
      hs      = s_valid && s_ready;
      step();
      guard++;
      if (hs) k++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("stream_words_accepted", k, n);
  endtask

  // Full job: stream, confirm the single start pulse, then play the controller.
  task automatic run_job(input bit directed, input bit gaps, input int last_at, input bit chk_bram);
    bit found = 0;
    fill_job(directed);
    s0 = n_starts;
    w0 = n_writes;
    stream(JOB, last_at, gaps);
    for (int i = 0; i < 10 && !found; i++) begin
      if (pe_start) found = 1;
      else step();
    end
    check("start_seen", found, 1);
    check("busy_in_job", busy, 1);
    step();
    check("start_after_last_write", start_cyc, last_we_cyc + 1);
    check("write_count", n_writes - w0, JOB);
    if (chk_bram)
      for (int k = 0; k < JOB; k++) check("bram_word", mem[k], job[k]);
    for (int r = 0; r < RES; r++) begin
      res[r]   = directed ? 32'(100 + r) : $urandom;
      ctl_we   = 1'b1;
      ctl_addr = 8'(r);
      ctl_data = res[r];
      step();
    end
    ctl_we = 1'b0;
    step();
    step();
    check("single_start", n_starts - s0, 1);
    check("no_write_in_busy", n_writes - w0, JOB);
  endtask

  // done_len < 0 keeps pe_done high throughout; ready_mode 1 = m_ready 1,0,0,1 pattern.
  task automatic drain(input int n_take, input int done_len, input int ready_mode);
    int          got = 0;
    int          first_v = -1;
    logic        hold = 1'b0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    for (int i = 0; i < 3000 && got < n_take; i++) begin
      pe_done = (done_len < 0) ? 1'b1 : (i < done_len);
      if (m_valid && first_v < 0) first_v = i;
      if (hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hd);
        check("hold_last", m_last, hl);
      end
      m_ready = (ready_mode == 0) ? 1'b1 : ((i % 4) == 0 || (i % 4) == 3);
      if (m_valid && m_ready) begin
        check("out_data", m_data, res[got]);
        check("out_last", m_last, got == RES - 1);
        got++;
      end
      hold = m_valid && !m_ready;
      hd   = m_data;
      hl   = m_last;
      step();
    end
    check("first_valid_latency", first_v, 3);
    check("drain_count", got, n_take);
  endtask

  initial begin
    reset = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    pe_done = 1'b0; ctl_we = 1'b0; ctl_addr = '0; ctl_data = '0;
    step();
    step();
    check_idle_zero("rst");
    reset = 1'b0;
    step();
    check("rst_release_s_ready", s_ready, 1);
    check("rst_release_busy", busy, 0);

    // Directed job: A = 1..64, B = 2, results 100+r.
    run_job(1'b1, 1'b0, JOB - 1, 1'b1);
    drain(RES, 6, 0);
    step();
    check("job1_idle", busy, 0);
    check("job1_err", err, 0);
    check("job1_s_ready", s_ready, 1);

    // Random job with input gaps and back-pressured output.
    run_job(1'b0, 1'b1, JOB - 1, 1'b1);
    drain(RES, 6, 1);
    step();
    check("job2_idle", busy, 0);

    // Early s_last on word 50.
    fill_job(1'b0);
    s0 = n_starts;
    stream(50, 49, 1'b0);
    step();
    step();
    check("early_last_err", err, 1);
    check("early_last_idle", busy, 0);
    check("early_last_no_start", n_starts - s0, 0);
    check("early_last_s_ready", s_ready, 1);

    // Clean job afterwards; err stays set.
    run_job(1'b0, 1'b0, JOB - 1, 1'b0);
    drain(RES, 6, 0);
    step();
    check("job4_err_sticky", err, 1);
    check("job4_idle", busy, 0);

    // Reset during FILL at word 30.
    fill_job(1'b0);
    stream(30, -1, 1'b0);
    s_valid = 1'b1;
    s_data  = job[30];
    reset   = 1'b1;
    step();
    check_idle_zero("rst_fill");
    reset   = 1'b0;
    s_valid = 1'b0;
    w0 = n_writes;
    repeat (5) step();
    check("rst_fill_no_write", n_writes - w0, 0);
    check("rst_fill_idle", busy, 0);

    // Reset during DRAIN after 10 results.
    run_job(1'b0, 1'b0, JOB - 1, 1'b0);
    drain(10, 6, 0);
    reset = 1'b1;
    step();
    check_idle_zero("rst_drain");
    reset = 1'b0;
    w0 = n_writes;
    repeat (5) step();
    check("rst_drain_no_write", n_writes - w0, 0);
    check("rst_drain_m_valid", m_valid, 0);
    check("rst_drain_idle", busy, 0);

    // Missing s_last on the final word, and pe_done still high back in IDLE.
    run_job(1'b0, 1'b1, -1, 1'b1);
    check("missing_last_err", err, 1);
    drain(RES, -1, 0);
    check("done_high_idle", busy, 0);
    check("done_high_s_ready0", s_ready, 0);
    step();
    step();
    check("done_high_s_ready_hold", s_ready, 0);
    pe_done = 1'b0;
    check("done_fall_same_cycle", s_ready, 0);
    step();
    check("done_fall_s_ready1", s_ready, 1);

    check("we_all_ones", bad_we, 0);
    check("addr_word_aligned", bad_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
